// File: rtl/md_pkg.sv
// Shared types for the EX-stage mul/div sequencer: instruction encodings, FSM states
// and HI/LO reset values.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MFHI  = 3'd6,
        MD_MFLO  = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE     = 2'd0,
        MD_MUL_WAIT = 2'd1,
        MD_DIV_WAIT = 2'd2,
        MD_DONE     = 2'd3
    } md_state_t;

    localparam logic [31:0] MD_HI_RST  = 32'h0000_0000;
    localparam logic [31:0] MD_LO_RST  = 32'h0000_0000;
    localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair: independent write enables sharing one 64-bit
// {hi,lo} write port, asynchronous active-low reset.
module hilo_regs
    import md_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_we_hi,
    input  logic        i_we_lo,
    input  logic [63:0] i_wdata,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_hi <= MD_HI_RST;
            r_lo <= MD_LO_RST;
        end else begin
            if (i_we_hi) r_hi <= i_wdata[63:32];
            if (i_we_lo) r_lo <= i_wdata[31:0];
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// EX-stage sequencer for MULT/MULTU/DIV/DIVU plus MTHI/MTLO/MFHI/MFLO; owns HI/LO.
// Optional build macro MD_ZERO_DIV_FAST_EN: divide-by-zero bypasses the divider.
module muldiv_hilo_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_TMO = 40
)(
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        adv,
    input  logic        flush,
    output logic        stallreq,
    output logic        mul_start,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam logic [15:0] MUL_CNT_INIT = 16'(MUL_LAT - 1);
    localparam logic [15:0] DIV_TMO_LAST = 16'((DIV_TMO > 0) ? DIV_TMO - 1 : 0);

    md_state_t   r_state;
    logic [15:0] r_cnt;
    logic [31:0] r_mul_a, r_mul_b, r_div_a, r_div_b;
    logic        r_mul_signed, r_div_signed;

    md_op_t      w_op;
    logic        w_idle, w_signed, w_is_mul, w_is_div;
    logic        w_mul_issue, w_div_req, w_div_zero, w_div_issue, w_div_tmo;
    logic        w_mul_wr, w_div_wr, w_mt_wr, w_we_hi, w_we_lo;
    logic [63:0] w_wdata;

    assign w_op     = md_op_t'(op);
    assign w_idle   = (r_state == MD_IDLE);
    assign w_signed = (w_op == MD_MULT) || (w_op == MD_DIV);
    assign w_is_mul = op_valid && ((w_op == MD_MULT) || (w_op == MD_MULTU));
    assign w_is_div = op_valid && ((w_op == MD_DIV)  || (w_op == MD_DIVU));

    assign w_mul_issue = w_idle && w_is_mul && !flush;
    assign w_div_req   = w_idle && w_is_div && !flush;
`ifdef MD_ZERO_DIV_FAST_EN
    assign w_div_zero  = w_div_req && (src_b == 32'd0);
`else
    assign w_div_zero  = 1'b0;
`endif
    assign w_div_issue = w_div_req && !w_div_zero;
    assign w_div_tmo   = (DIV_TMO != 0) && (r_cnt == DIV_TMO_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= MD_IDLE;
            r_cnt        <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_signed <= 1'b0;
            r_div_a      <= '0;
            r_div_b      <= '0;
            r_div_signed <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (w_mul_issue) begin
                        r_state      <= MD_MUL_WAIT;
                        r_cnt        <= MUL_CNT_INIT;
                        r_mul_a      <= src_a;
                        r_mul_b      <= src_b;
                        r_mul_signed <= w_signed;
                    end else if (w_div_issue) begin
                        r_state      <= MD_DIV_WAIT;
                        r_cnt        <= '0;
                        r_div_a      <= src_a;
                        r_div_b      <= src_b;
                        r_div_signed <= w_signed;
                    end else if (w_div_zero) begin
                        r_state      <= MD_DONE;
                    end
                end
                MD_MUL_WAIT: begin
                    if (flush)               r_state <= MD_IDLE;
                    else if (r_cnt == 16'd0) r_state <= MD_DONE;
                    else                     r_cnt   <= r_cnt - 16'd1;
                end
                MD_DIV_WAIT: begin
                    // flush outranks a same-cycle div_ready; ready outranks the timeout
                    if (flush)                       r_state <= MD_IDLE;
                    else if (div_ready || w_div_tmo) r_state <= MD_DONE;
                    else                             r_cnt   <= r_cnt + 16'd1;
                end
                MD_DONE: begin
                    if (flush || adv) r_state <= MD_IDLE;
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign w_mul_wr = (r_state == MD_MUL_WAIT) && !flush && (r_cnt == 16'd0);
    assign w_div_wr = (r_state == MD_DIV_WAIT) && !flush && div_ready;
    assign w_mt_wr  = w_idle && op_valid && adv && !flush;
    assign w_we_hi  = w_mul_wr || w_div_wr || w_div_zero || (w_mt_wr && (w_op == MD_MTHI));
    assign w_we_lo  = w_mul_wr || w_div_wr || w_div_zero || (w_mt_wr && (w_op == MD_MTLO));

    always_comb begin
        w_wdata = {src_a, src_a};
        if (w_mul_wr)        w_wdata = mul_result;
        else if (w_div_wr)   w_wdata = div_result;
        else if (w_div_zero) w_wdata = {src_a, MD_DIV0_LO};
    end

    hilo_regs u_hilo (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_we_hi  (w_we_hi),
        .i_we_lo  (w_we_lo),
        .i_wdata  (w_wdata),
        .o_hi     (hi),
        .o_lo     (lo)
    );

    // Issue-cycle operands go straight out so the units start in the same cycle as EX.
    assign stallreq   = w_mul_issue || w_div_req ||
                        (r_state == MD_MUL_WAIT) || (r_state == MD_DIV_WAIT);
    assign mul_start  = w_mul_issue;
    assign mul_a      = w_mul_issue ? src_a    : r_mul_a;
    assign mul_b      = w_mul_issue ? src_b    : r_mul_b;
    assign mul_signed = w_mul_issue ? w_signed : r_mul_signed;
    assign div_start  = w_div_issue || ((r_state == MD_DIV_WAIT) && !flush);
    assign div_a      = w_div_issue ? src_a    : r_div_a;
    assign div_b      = w_div_issue ? src_b    : r_div_b;
    assign div_signed = w_div_issue ? w_signed : r_div_signed;
    assign div_annul  = (r_state == MD_DIV_WAIT) && flush;

    always_comb begin
        rdata = '0;
        if (op_valid && (w_op == MD_MFHI))      rdata = hi;
        else if (op_valid && (w_op == MD_MFLO)) rdata = lo;
    end

endmodule
